e203_tcm_ram_ctrl: RTL
======================

E203_TCM_RAM_CTRL -- requirements
Module: e203_tcm_ram_ctrl

Interface
REQ-001 SHALL have parameter AW, default 16: RAM word-address width.
REQ-002 SHALL have parameter DW, default 32: data width.
REQ-003 SHALL have parameter MW, default 4: write-mask width, DW/8.
REQ-004 SHALL have port clk  input  1: the block's single clock, rising edge.
REQ-005 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port icb_cmd_valid  input  1: command valid.
REQ-007 SHALL have port icb_cmd_ready  output  1: command accepted.
REQ-008 SHALL have port icb_cmd_read  input  1: 1 = read, 0 = write.
REQ-009 SHALL have port icb_cmd_addr  input  AW: word address.
REQ-010 SHALL have port icb_cmd_wdata  input  DW: write data.
REQ-011 SHALL have port icb_cmd_wmask  input  MW: byte enables.
REQ-012 SHALL have port icb_rsp_valid  output  1: response valid.
REQ-013 SHALL have port icb_rsp_ready  input  1: response accepted.
REQ-014 SHALL have port icb_rsp_rdata  output  DW: read data; 0 for writes.
REQ-015 SHALL have port icb_rsp_err  output  1: response error; constant 0.
REQ-016 SHALL have ports ram_cs, ram_we  output  1, ram_addr  output  AW, ram_wem  output  MW, ram_din  output  DW: the SRAM command side.
REQ-017 SHALL have port ram_dout  input  DW: SRAM read data, valid the cycle after a read cs.
REQ-018 SHALL have port clk_ram_en  output  1: RAM clock-gate enable.

Function
REQ-019 SHALL complete a command handshake when icb_cmd_valid & icb_cmd_ready; on that cycle ram_cs SHALL be 1, combinationally.
REQ-020 SHALL drive the RAM from the command on a handshake cycle:
  - ram_we = ~icb_cmd_read
  - ram_addr = icb_cmd_addr
  - ram_din = icb_cmd_wdata
  - ram_wem = icb_cmd_read ? 0 : icb_cmd_wmask
REQ-021 SHALL assert ram_cs only on handshake cycles.
REQ-022 SHALL drive clk_ram_en = ram_cs | (rsp state != IDLE).
REQ-023 SHALL implement the response state machine:
  - IDLE: no response pending.
  - LIVE: first response cycle; rdata comes from ram_dout.
  - HOLD: response stalled; rdata comes from the held copy.
REQ-024 SHALL transition the state machine as follows:
  - A handshake moves the state to LIVE.
  - From LIVE or HOLD, a cycle with rsp_ready=1 and no new handshake moves the state to IDLE.
  - LIVE with rsp_ready=0 moves to HOLD.
  - HOLD with rsp_ready=0 stays in HOLD.
REQ-025 SHALL assert icb_rsp_valid whenever the state is LIVE or HOLD: exactly one response per command, in order, with 1-cycle latency.
REQ-026 SHALL drive icb_cmd_ready = (state==IDLE) | icb_rsp_ready, so a response retiring and a new command being accepted in the same cycle gives a back-to-back return to LIVE.
REQ-027 SHALL record the read/write type of the accepted command in a 1-bit flag; icb_rsp_rdata SHALL be 0 when that flag marks a write.
REQ-028 SHALL never issue a RAM access while a stalled response is pending and icb_rsp_ready=0, so the RAM output is not overwritten.

Reset
REQ-029 SHALL, while rst_n=0, force the state to IDLE, icb_rsp_valid=0, the type flag to 0 and the held data to 0.
REQ-030 SHALL drop any pending response when reset asserts mid-transaction; it is not replayed.
REQ-031 SHALL hold all outputs at 0 in reset except icb_cmd_ready, which is 1.

Configuration
REQ-032 SHALL, with macro E203_TCM_CTRL_RSP_HOLD_EN defined, capture ram_dout into a DW-bit register on LIVE->HOLD and supply rdata in HOLD from that register.
REQ-033 SHALL, without E203_TCM_CTRL_RSP_HOLD_EN, omit the register and supply rdata in HOLD from ram_dout, relying on the SRAM holding its output while cs=0; state sequencing SHALL be identical in both builds.

Verification
REQ-034 Read addr 0x0010 with RAM preloaded 0xDEADBEEF and rsp_ready=1 -> ram_cs=1, ram_we=0 on the handshake cycle; rsp_valid=1 with rdata=0xDEADBEEF on the next cycle.
REQ-035 Write addr 0x0004, wdata 0x12345678, wmask 4'b0011, then read it back -> ram_wem=4'b0011; the write response has rdata=0; the readback has the low half 0x5678 and the upper half unchanged.
REQ-036 Read, then rsp_ready=0 for 3 cycles -> state HOLD, cmd_ready=0, no ram_cs, rdata stable in both builds.
REQ-037 cmd_valid held 1 with rsp_ready=1 for 8 reads -> one handshake and one response per cycle, in address order.
REQ-038 rst_n pulsed low while in HOLD -> rsp_valid=0 immediately and cmd_ready=1; no stale response after release.

Source files
------------

// File: rtl/e203_tcm_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : e203_tcm_ram_ctrl
// Purpose : Bridges a single-outstanding ICB command/response channel to a
//           synchronous single-port SRAM. Each command accepted on the ICB
//           side becomes one SRAM access in the same cycle. The response is
//           returned one cycle later and can be back-pressured indefinitely.
//
// Ports   :
//   clk, rst_n          - clock (rising edge), asynchronous active-low reset
//   icb_cmd_*           - command channel (valid/ready, read, addr, wdata, wmask)
//   icb_rsp_*           - response channel (valid/ready, rdata, err)
//   ram_cs/we/addr/wem/din - SRAM command side
//   ram_dout            - SRAM read data, valid the cycle after a read cs
//   clk_ram_en          - SRAM clock-gate enable
//
// Config  : E203_TCM_CTRL_RSP_HOLD_EN
//           defined   - a DW-bit register captures ram_dout when a response
//                       stalls. Read data for a held response comes from it.
//           undefined - no capture register. Read data for a held response
//                       comes straight from ram_dout, because the SRAM keeps
//                       its output while cs is low.
//
// Revision: 1.0 - initial release
// ============================================================================
module e203_tcm_ram_ctrl #(
  parameter int AW = 16,
  parameter int DW = 32,
  parameter int MW = 4
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          icb_cmd_valid,
  output logic          icb_cmd_ready,
  input  logic          icb_cmd_read,
  input  logic [AW-1:0] icb_cmd_addr,
  input  logic [DW-1:0] icb_cmd_wdata,
  input  logic [MW-1:0] icb_cmd_wmask,

  output logic          icb_rsp_valid,
  input  logic          icb_rsp_ready,
  output logic [DW-1:0] icb_rsp_rdata,
  output logic          icb_rsp_err,

  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [MW-1:0] ram_wem,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,

  output logic          clk_ram_en
);

  // Response state machine
  //   ST_IDLE : no response pending
  //   ST_LIVE : first response cycle, so the SRAM output is fresh
  //   ST_HOLD : response stalled by the requester
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LIVE = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_rsp_read;   // 1 = the pending response belongs to a read
  logic          w_hsk;
  logic [DW-1:0] w_rdata;

  // A new command is accepted only when the response slot is free or is
  // retiring this cycle. While a response is stalled, cmd_ready therefore
  // stays low and the SRAM output cannot be overwritten.
  // The handshake is qualified with rst_n so the SRAM port stays quiet
  // while reset is held, even if a requester drives cmd_valid.
  assign icb_cmd_ready = (r_state == ST_IDLE) | icb_rsp_ready;
  assign w_hsk         = icb_cmd_valid & icb_cmd_ready & rst_n;

  // The SRAM command is driven only on a handshake cycle. At all other
  // times the SRAM command outputs are zero.
  assign ram_cs   = w_hsk;
  assign ram_we   = w_hsk & ~icb_cmd_read;
  assign ram_addr = w_hsk ? icb_cmd_addr  : '0;
  assign ram_din  = w_hsk ? icb_cmd_wdata : '0;
  assign ram_wem  = (w_hsk & ~icb_cmd_read) ? icb_cmd_wmask : '0;

  assign clk_ram_en = ram_cs | (r_state != ST_IDLE);

  // -------------------------------------------------------------------------
  // State register and command-type flag
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_rsp_read <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hsk) begin
        r_rsp_read <= icb_cmd_read;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic. A handshake always lands in LIVE, which also covers
  // the back-to-back case where one response retires while the next
  // command is accepted.
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    if (w_hsk) begin
      w_state_nxt = ST_LIVE;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_IDLE;
        ST_LIVE: w_state_nxt = icb_rsp_ready ? ST_IDLE : ST_HOLD;
        ST_HOLD: w_state_nxt = icb_rsp_ready ? ST_IDLE : ST_HOLD;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Held read data for a stalled response
  // -------------------------------------------------------------------------
`ifdef E203_TCM_CTRL_RSP_HOLD_EN
  logic [DW-1:0] r_hold_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_data <= '0;
    end else if ((r_state == ST_LIVE) && (w_state_nxt == ST_HOLD)) begin
      r_hold_data <= ram_dout;
    end
  end

  always_comb begin
    w_rdata = '0;
    if (r_rsp_read) begin
      case (r_state)
        ST_LIVE: w_rdata = ram_dout;
        ST_HOLD: w_rdata = r_hold_data;
        default: w_rdata = '0;
      endcase
    end
  end
`else
  // The SRAM holds its output while cs is low, and no access can start
  // while a response is pending. ram_dout is therefore still valid in HOLD.
  always_comb begin
    w_rdata = '0;
    if (r_rsp_read && (r_state != ST_IDLE)) begin
      w_rdata = ram_dout;
    end
  end
`endif

  assign icb_rsp_valid = (r_state == ST_LIVE) | (r_state == ST_HOLD);
  assign icb_rsp_rdata = w_rdata;
  assign icb_rsp_err   = 1'b0;

endmodule
`default_nettype wire
